ddr3_cmd_responder: RTL and testbench

Single-clock, pin-side DDR3 command responder. It decodes the command bus driven by the DDR3 PHY, tracks per-bank open rows, and applies CL/CWL from mode-register writes. It stores BL8 write bursts into a small on-chip array and returns read bursts at the programmed latency. It sits opposite the PHY in controller/PHY testbenches and FPGA loopback builds, with data folded to the DFI double-width bus: one beat is 2×DDR3_WIDTH per clock, and BL8 takes 4 clocks.

---
 rtl/ddr3_defs.sv | 19 +
 rtl/shift_register.sv | 29 ++
 rtl/ddr3_cmd_responder.sv | 152 +++++++++++++++
 tb/tb_ddr3_cmd_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_defs.sv
// ddr3_defs: command encodings, burst shape and mode-register latency mapping for the DDR3 responder
package ddr3_defs;
    typedef enum logic [2:0] {
        CMD_MRS = 3'd0,
        CMD_REF = 3'd1,
        CMD_PRE = 3'd2,
        CMD_ACT = 3'd3,
        CMD_WR  = 3'd4,
        CMD_RD  = 3'd5,
        CMD_ZQ  = 3'd6,
        CMD_NOP = 3'd7
    } cmd_t;
    localparam int         BURST_BEATS  = 4;
    localparam int         TCCD         = 4;
    localparam logic [3:0] CL_OFFSET    = 4'd4;
    localparam logic [3:0] CWL_OFFSET   = 4'd5;
    localparam logic [2:0] CL_CODE_MIN  = 3'd1;
    localparam logic [2:0] CWL_CODE_MAX = 3'd5;
endpackage

// File: rtl/shift_register.sv
// shift_register: delay line shifting toward q, new data dropped in at a run-time selected stage
module shift_register #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [$clog2(DEPTH)-1:0] tap,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q
);
    logic [DEPTH*WIDTH-1:0] line;
    logic [DEPTH*WIDTH-1:0] line_nxt;

    // Advance every entry one stage toward the output; a new entry lands tap stages away from it
    always_comb begin
        line_nxt = {WIDTH'(0), line[DEPTH*WIDTH-1:WIDTH]};
        if (load) line_nxt[tap*WIDTH +: WIDTH] = d;
    end

    // Stage storage, cleared so pending entries vanish on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) line <= '0;
        else          line <= line_nxt;
    end

    assign q = line[WIDTH-1:0];
endmodule

// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: pin-side DDR3 model decoding commands, tracking banks and serving BL8 bursts
module ddr3_cmd_responder
    import ddr3_defs::*;
#(
    parameter int DDR3_WIDTH     = 16,
    parameter int ADDR_BITS      = 14,
    parameter int ROW_BITS       = 2,
    parameter int COL_BITS       = 6,
    parameter int DEFAULT_CL     = 6,
    parameter int DEFAULT_CWL    = 6,
    parameter int MAX_RW_LATENCY = 12
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cke_i,
    input  logic                      cs_ni,
    input  logic                      ras_ni,
    input  logic                      cas_ni,
    input  logic                      we_ni,
    input  logic [2:0]                ba_i,
    input  logic [ADDR_BITS-1:0]      a_i,
    input  logic [2*DDR3_WIDTH-1:0]   wr_data_i,
    input  logic [2*DDR3_WIDTH/8-1:0] wr_mask_i,
    output logic                      rd_valid_o,
    output logic [2*DDR3_WIDTH-1:0]   rd_data_o,
    output logic [7:0]                bank_open_o,
    output logic                      err_o
);
    localparam int DW    = 2 * DDR3_WIDTH;
    localparam int MW    = DW / 8;
    localparam int BW    = 3 + ROW_BITS + COL_BITS - 3;
    localparam int AW    = BW + 2;
    localparam int E     = BW + 2;
    localparam int DEPTH = MAX_RW_LATENCY + 4;
    localparam int TW    = $clog2(DEPTH);

    cmd_t                cmd;
    logic                cmd_v, is_rw, rw_go, act_go, mrs_cl, mrs_cwl, cl_ok, cwl_ok, err_d, err_p;
    logic [3:0]          cl, cwl, lat;
    logic [2:0]          ccd;
    logic [DEPTH-1:0]    occ, win;
    logic [ROW_BITS-1:0] row_tab [8];
    logic [E-1:0]        q;
    logic [1:0]          left;
    logic                seq_rd, seq_wr, start, beat_rd, beat_wr;
    logic [BW-1:0]       seq_base;
    logic [AW-1:0]       beat_addr;
    logic [DW-1:0]       mem [2**AW];
    logic                unused_addr;

    assign unused_addr = ^a_i;

    // Decode the pins and judge each command against bank state, tCCD spacing and data-bus occupancy
    always_comb begin
        cmd     = cmd_t'({ras_ni, cas_ni, we_ni});
        cmd_v   = cke_i & ~cs_ni;
        is_rw   = cmd_v & ((cmd == CMD_RD) | (cmd == CMD_WR));
        lat     = (cmd == CMD_RD) ? cl : cwl;
        win     = DEPTH'(4'hF) << lat;
        rw_go   = is_rw & bank_open_o[ba_i] & (ccd >= 3'(TCCD)) & ~|(occ & win);
        act_go  = cmd_v & (cmd == CMD_ACT) & ~bank_open_o[ba_i];
        mrs_cl  = cmd_v & (cmd == CMD_MRS) & (ba_i == 3'd0);
        mrs_cwl = cmd_v & (cmd == CMD_MRS) & (ba_i == 3'd2);
        cl_ok   = a_i[6:4] >= CL_CODE_MIN;
        cwl_ok  = a_i[5:3] <= CWL_CODE_MAX;
        err_d   = (is_rw & ~rw_go)
                | (cmd_v & (cmd == CMD_ACT) & bank_open_o[ba_i])
                | (cmd_v & (cmd == CMD_REF) & |bank_open_o)
                | (mrs_cl & ~cl_ok)
                | (mrs_cwl & ~cwl_ok);
    end

    // Bank flags, mode latencies, RD/WR spacing counter, future data-edge map and delayed error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_open_o <= '0;
            cl          <= 4'(DEFAULT_CL);
            cwl         <= 4'(DEFAULT_CWL);
            ccd         <= 3'(TCCD);
            occ         <= '0;
            err_p       <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (act_go) bank_open_o[ba_i] <= 1'b1;
            if (cmd_v && cmd == CMD_PRE) bank_open_o <= a_i[10] ? '0 : bank_open_o & ~(8'd1 << ba_i);
            if (mrs_cl && cl_ok) cl <= {1'b0, a_i[6:4]} + CL_OFFSET;
            if (mrs_cwl && cwl_ok) cwl <= {1'b0, a_i[5:3]} + CWL_OFFSET;
            ccd   <= rw_go ? 3'd1 : (ccd < 3'(TCCD)) ? ccd + 3'd1 : ccd;
            occ   <= (occ | (rw_go ? win : '0)) >> 1;
            err_p <= err_d;
            err_o <= err_p;
        end
    end

    // Open-row table; an entry only matters while its bank is open
    always_ff @(posedge clock) begin
        if (act_go) row_tab[ba_i] <= a_i[ROW_BITS-1:0];
    end

    // Accepted bursts enter latency-1 stages from the head so each keeps the latency it was issued with
    shift_register #(.WIDTH(E), .DEPTH(DEPTH)) u_sched (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (rw_go),
        .tap     (TW'(lat - 4'd1)),
        .d       ({cmd == CMD_RD, cmd == CMD_WR, ba_i, row_tab[ba_i], a_i[COL_BITS-1:3]}),
        .q       (q)
    );

    // Current beat: a burst start from the pipeline, otherwise the continuing burst's next beat
    always_comb begin
        start     = q[E-1] | q[E-2];
        beat_rd   = start ? q[E-1] : (left != 2'd0) & seq_rd;
        beat_wr   = start ? q[E-2] : (left != 2'd0) & seq_wr;
        beat_addr = start ? {q[BW-1:0], 2'd0} : {seq_base, 2'd0 - left};
    end

    // Beat sequencer walking beats 1..3 after each burst start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            left     <= '0;
            seq_rd   <= 1'b0;
            seq_wr   <= 1'b0;
            seq_base <= '0;
        end else if (start) begin
            left     <= 2'(BURST_BEATS - 1);
            seq_rd   <= q[E-1];
            seq_wr   <= q[E-2];
            seq_base <= q[BW-1:0];
        end else if (left != 2'd0) begin
            left     <= left - 2'd1;
        end
    end

    // Registered read beat; data bus idles at zero between bursts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= beat_rd;
            rd_data_o  <= beat_rd ? mem[beat_addr] : '0;
        end
    end

    // Byte-masked write port; deliberately unreset so contents survive reset
    always_ff @(posedge clock) begin
        if (beat_wr)
            for (int i = 0; i < MW; i++)
                if (!wr_mask_i[i]) mem[beat_addr][8*i +: 8] <= wr_data_i[8*i +: 8];
    end
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb_ddr3_cmd_responder: directed command sequences with hand-computed beats, latencies and error pulses
module tb_ddr3_cmd_responder;
    import ddr3_defs::*;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]   ba;
    logic [13:0]  addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_mask;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic [7:0]   bank_open;
    logic         err;
    int           checks = 0;
    int           errors = 0;
    int           n;

    localparam logic [127:0] D1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    always #5 clock = ~clock;

    ddr3_cmd_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cke_i       (cke),
        .cs_ni       (cs_n),
        .ras_ni      (ras_n),
        .cas_ni      (cas_n),
        .we_ni       (we_n),
        .ba_i        (ba),
        .a_i         (addr),
        .wr_data_i   (wr_data),
        .wr_mask_i   (wr_mask),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .bank_open_o (bank_open),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic drive(input cmd_t c, input logic [2:0] b, input logic [13:0] a);
        {ras_n, cas_n, we_n} = c;
        cs_n = 1'b0;
        ba   = b;
        addr = a;
        @(negedge clock);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
    endtask

    task automatic write_burst(input logic [2:0] b, input logic [13:0] a, input logic [127:0] d, input logic [3:0] m0);
        drive(CMD_WR, b, a);
        idle(5);
        for (int k = 0; k < 4; k++) begin
            wr_data = d[32*k +: 32];
            wr_mask = (k == 0) ? m0 : 4'h0;
            idle(1);
        end
        wr_data = 32'hDEADBEEF;
        wr_mask = 4'h0;
    endtask

    task automatic read_expect(input string tag, input logic [2:0] b, input logic [13:0] a, input int lat, input logic [127:0] exp);
        drive(CMD_RD, b, a);
        idle(lat - 1);
        check({tag, "_early"}, rd_valid, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check({tag, "_valid"}, rd_valid, 1);
            check({tag, "_data"}, rd_data, exp[32*k +: 32]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cke = 1'b1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        ba = 3'd0;
        addr = 14'd0;
        wr_data = 32'hDEADBEEF;
        wr_mask = 4'h0;
        idle(2);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_bank", bank_open, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        idle(1);

        drive(CMD_ACT, 3'd1, 14'd2);
        check("act_open", bank_open, 8'h02);
        idle(3);
        write_burst(3'd1, 14'd8, D1, 4'h0);
        idle(6);
        read_expect("rd_basic", 3'd1, 14'd8, 6, D1);
        idle(1);
        check("rd_basic_end", rd_valid, 0);
        check("no_err", err, 0);

        drive(CMD_MRS, 3'd0, 14'h030);
        read_expect("rd_cl7", 3'd1, 14'd8, 7, D1);
        idle(1);
        drive(CMD_MRS, 3'd0, 14'h070);
        read_expect("rd_cl11", 3'd1, 14'd8, 11, D1);
        idle(1);

        drive(CMD_MRS, 3'd2, 14'h030);
        check("mrs_err_lag", err, 0);
        idle(1);
        check("mrs_err", err, 1);
        idle(1);
        check("mrs_err_pulse", err, 0);
        drive(CMD_MRS, 3'd0, 14'h020);

        write_burst(3'd1, 14'd16, {4{32'hFFFFFFFF}}, 4'h0);
        idle(1);
        write_burst(3'd1, 14'd16, 128'h0, 4'b0101);
        idle(1);
        read_expect("rd_mask", 3'd1, 14'd16, 6, {96'h0, 32'h00FF00FF});
        idle(1);

        drive(CMD_RD, 3'd1, 14'd8);
        idle(3);
        drive(CMD_RD, 3'd1, 14'd8);
        idle(1);
        check("b2b_early", rd_valid, 0);
        for (int k = 0; k < 8; k++) begin
            idle(1);
            check("b2b_valid", rd_valid, 1);
            check("b2b_data", rd_data, D1[32*(k%4) +: 32]);
        end
        idle(1);
        check("b2b_end", rd_valid, 0);
        check("b2b_err", err, 0);
        idle(4);

        drive(CMD_RD, 3'd1, 14'd8);
        idle(1);
        drive(CMD_RD, 3'd1, 14'd8);
        check("ccd_err_lag", err, 0);
        idle(1);
        check("ccd_err", err, 1);
        n = 0;
        repeat (10) begin
            idle(1);
            n += int'(rd_valid);
        end
        check("ccd_beats", n, 4);
        idle(2);

        drive(CMD_ACT, 3'd1, 14'd3);
        idle(1);
        check("act_dup_err", err, 1);
        drive(CMD_RD, 3'd3, 14'd8);
        check("err_gap", err, 0);
        idle(1);
        check("rd_closed_err", err, 1);
        drive(CMD_REF, 3'd0, 14'd0);
        idle(1);
        check("ref_open_err", err, 1);
        n = 0;
        repeat (12) begin
            idle(1);
            n += int'(rd_valid);
        end
        check("err_no_beats", n, 0);
        check("err_bank_kept", bank_open, 8'h02);
        read_expect("rd_row_kept", 3'd1, 14'd8, 6, D1);
        idle(1);

        drive(CMD_ACT, 3'd5, 14'd0);
        check("act5", bank_open, 8'h22);
        drive(CMD_PRE, 3'd5, 14'd0);
        check("pre5", bank_open, 8'h02);
        drive(CMD_ACT, 3'd6, 14'd0);
        drive(CMD_PRE, 3'd0, 14'h400);
        check("pre_all", bank_open, 8'h00);
        check("pre_no_err", err, 0);

        drive(CMD_ACT, 3'd1, 14'd2);
        idle(3);
        drive(CMD_RD, 3'd1, 14'd8);
        idle(5);
        check("abort_early", rd_valid, 0);
        idle(1);
        check("abort_beat0", rd_valid, 1);
        idle(1);
        check("abort_beat1", rd_valid, 1);
        reset_n = 1'b0;
        #1;
        check("abort_valid", rd_valid, 0);
        check("abort_data", rd_data, 0);
        idle(2);
        reset_n = 1'b1;
        n = 0;
        repeat (8) begin
            idle(1);
            n += int'(rd_valid);
        end
        check("abort_no_beats", n, 0);
        check("abort_bank", bank_open, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
